// File: rtl/comp_button_if.sv
// comp_button_if -- bus bundle for the computer-player button comparator.
//
// Signals:
//   Q   [WIDTH-1:0]  unsigned pseudo-random threshold (LFSR value)
//   SW  [WIDTH-2:0]  unsigned difficulty setting from switches
//   out              registered computer-player "button press"
//
// Modports:
//   master -- stimulus side: drives Q/SW, observes out
//   slave  -- comp_button side: consumes Q/SW, drives out
interface comp_button_if #(
  parameter int unsigned WIDTH = 10
);
  logic [WIDTH-1:0] Q;
  logic [WIDTH-2:0] SW;
  logic             out;

  modport master (
    output Q,
    output SW,
    input  out
  );

  modport slave (
    input  Q,
    input  SW,
    output out
  );
endinterface

// File: rtl/comp_button.sv
// comp_button -- computer-player button for a reaction game.
//
// The difficulty switches SW, zero-extended to WIDTH bits, are compared
// against the pseudo-random threshold Q. When SW > Q (unsigned, strict) the
// computer "presses" its button. The compare result is registered, so out
// follows the inputs with one cycle of latency and never has a combinational
// path from Q/SW.
//
// Ports:
//   clk    -- system clock, all state updates on the rising edge
//   reset  -- synchronous active-high reset, clears all state
//   bus    -- comp_button_if.slave (Q, SW in; out out)
//
// Parameter:
//   WIDTH  -- bit width of Q (minimum 2); SW is WIDTH-1 bits
//
// Configuration macro COMP_BUTTON_PULSE_EN:
//   undefined -- out is a level, high while the compare holds
//   defined   -- out is a one-cycle pulse on each 0->1 compare transition;
//                a compare already true on the first edge after reset counts
//                as a rising edge

// Purely combinational unsigned strict greater-than.
module comparator #(
  parameter int unsigned WIDTH = 10
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             true_false
);
  always_comb begin
    true_false = (A > B);
  end
endmodule

module comp_button #(
  parameter int unsigned WIDTH = 10
) (
  input  logic          clk,
  input  logic          reset,
  comp_button_if.slave  bus
);

  if (WIDTH < 2) begin : g_width_check
    $error("comp_button: WIDTH must be at least 2");
  end

  // SW is one bit narrower than Q; its implied MSB of 0 means any Q with
  // MSB set can never be beaten.
  logic [WIDTH-1:0] op_a;
  logic             compare;

  assign op_a = {1'b0, bus.SW};

  comparator #(
    .WIDTH(WIDTH)
  ) u_comparator (
    .A          (op_a),
    .B          (bus.Q),
    .true_false (compare)
  );

  // Level register of the compare result.
  logic cmp_q;

`ifdef COMP_BUTTON_PULSE_EN
  // The previous compare is exactly what cmp_q holds, so the edge detect
  // reuses it rather than keeping a duplicate flop. Both clear on reset,
  // which makes a compare already true after reset look like a rising edge.
  logic prev_cmp;
  logic pulse_q;

  assign prev_cmp = cmp_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cmp_q   <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      cmp_q   <= compare;
      pulse_q <= compare & ~prev_cmp;
    end
  end

  assign bus.out = pulse_q;
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      cmp_q <= 1'b0;
    end else begin
      cmp_q <= compare;
    end
  end

  assign bus.out = cmp_q;
`endif

endmodule

// File: tb/tb_comp_button.sv
// tb_comp_button -- directed and random checks for comp_button (WIDTH = 10).
// Expectations follow the COMP_BUTTON_PULSE_EN setting of the build.
module tb_comp_button;

  localparam int unsigned WIDTH = 10;

  logic clk;
  logic reset;

  comp_button_if #(.WIDTH(WIDTH)) bus ();

  comp_button #(
    .WIDTH(WIDTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: out=%0b expected=%0b (SW=%0d Q=%0d reset=%0b)",
               tag, got, exp, bus.SW, bus.Q, reset);
    end
  endtask

  // Apply inputs, take one rising edge, sample 1 time unit later.
  task automatic step(input logic [WIDTH-2:0] sw, input logic [WIDTH-1:0] q,
                      input logic rst);
    bus.SW = sw;
    bus.Q  = q;
    reset  = rst;
    @(posedge clk);
    #1;
  endtask

  // Watchdog: the bench only waits on clock edges, but never let it hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [WIDTH-2:0] rsw;
    logic [WIDTH-1:0] rq;
    logic             mcmp;
    logic             mprev;
    logic             mexp;

    bus.SW = '0;
    bus.Q  = '0;
    reset  = 1'b1;
    #2;

    // Reset held two cycles, then released with SW = 0, Q = 0.
    step(9'd0, 10'd0, 1'b1);
    check("reset_edge1", bus.out, 1'b0);
    step(9'd0, 10'd0, 1'b1);
    check("reset_edge2", bus.out, 1'b0);
    step(9'd0, 10'd0, 1'b0);
    check("first_release_eq0", bus.out, 1'b0);

`ifdef COMP_BUTTON_PULSE_EN
    // SW = 2 > Q = 1 held four cycles: one pulse only.
    step(9'd2, 10'd1, 1'b0);
    check("pulse_rise", bus.out, 1'b1);
    step(9'd2, 10'd1, 1'b0);
    check("pulse_hold1", bus.out, 1'b0);
    step(9'd2, 10'd1, 1'b0);
    check("pulse_hold2", bus.out, 1'b0);
    step(9'd2, 10'd1, 1'b0);
    check("pulse_hold3", bus.out, 1'b0);
    // Q = 3 for one cycle drops the compare; Q = 1 again re-arms one pulse.
    step(9'd2, 10'd3, 1'b0);
    check("pulse_drop", bus.out, 1'b0);
    step(9'd2, 10'd1, 1'b0);
    check("pulse_rerise", bus.out, 1'b1);
    step(9'd2, 10'd1, 1'b0);
    check("pulse_rerise_end", bus.out, 1'b0);
`else
    // Level mode: SW = 2 > Q = 1 -> high, Q = 3 -> low.
    step(9'd2, 10'd1, 1'b0);
    check("level_high", bus.out, 1'b1);
    step(9'd2, 10'd1, 1'b0);
    check("level_hold", bus.out, 1'b1);
    step(9'd2, 10'd3, 1'b0);
    check("level_low", bus.out, 1'b0);
`endif

    // Boundaries, entered from a compare-false state.
    step(9'd0, 10'd3, 1'b0);
    check("sw0_q3", bus.out, 1'b0);
    step(9'd5, 10'd5, 1'b0);
    check("equal_5_5", bus.out, 1'b0);
    step(9'd511, 10'd0, 1'b0);
    check("max_sw_q0", bus.out, 1'b1);
    step(9'd511, 10'd512, 1'b0);
    check("q_msb_set", bus.out, 1'b0);
    step(9'd511, 10'd511, 1'b0);
    check("equal_511", bus.out, 1'b0);
    step(9'd511, 10'd510, 1'b0);
    check("sw511_q510", bus.out, 1'b1);

    // Reset mid-press: out is high, reset with inputs unchanged clears it.
    step(9'd511, 10'd1023, 1'b0);
    check("pre_press_low", bus.out, 1'b0);
    step(9'd300, 10'd100, 1'b0);
    check("press_high", bus.out, 1'b1);
    step(9'd300, 10'd100, 1'b1);
    check("reset_mid_press", bus.out, 1'b0);
    // First edge after reset loads the compare; in pulse mode it is a rise.
    step(9'd300, 10'd100, 1'b0);
    check("post_reset_load", bus.out, 1'b1);
    step(9'd300, 10'd100, 1'b0);
`ifdef COMP_BUTTON_PULSE_EN
    check("post_reset_hold", bus.out, 1'b0);
`else
    check("post_reset_hold", bus.out, 1'b1);
`endif

    // Random pairs against a one-cycle-delayed reference. The last applied
    // compare (300 > 100) is true, so the model's previous compare starts at 1.
    mprev = 1'b1;
    for (int unsigned i = 0; i < 1000; i++) begin
      rsw = 9'($urandom_range(511, 0));
      rq  = 10'($urandom_range(1023, 0));
      // Bias some vectors toward the equal / adjacent boundary.
      if (i % 8 == 0) rq = {1'b0, rsw};
      if (i % 8 == 1) rq = {1'b0, rsw} - 10'd1;
      mcmp = ({1'b0, rsw} > rq);
`ifdef COMP_BUTTON_PULSE_EN
      mexp = mcmp & ~mprev;
`else
      mexp = mcmp;
`endif
      mprev = mcmp;
      step(rsw, rq, 1'b0);
      check("random", bus.out, mexp);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/comp_button.md
COMP_BUTTON -- requirements
Module: comp_button

Interface
REQ-001 Parameter: WIDTH, default 10, bit width of the Q comparison operand (minimum 2).
REQ-002 Port: clk  input  1  single system clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset, sampled on rising clk edge.
REQ-004 Port: Q  input  WIDTH  unsigned pseudo-random threshold (LFSR value from elsewhere).
REQ-005 Port: SW  input  WIDTH-1  unsigned difficulty setting from switches.
REQ-006 Port: out  output  1  computer-player "button press", registered.

Function
REQ-007 Operand A SHALL be SW zero-extended by one MSB to WIDTH bits ({1'b0, SW}); operand B SHALL be Q.
REQ-008 Comparison SHALL be done by an instantiated submodule named comparator, with ports A (WIDTH), B (WIDTH) and true_false (1).
REQ-009 comparator SHALL be purely combinational: true_false = 1 iff A > B, unsigned, strictly greater.
REQ-010 Equal operands SHALL give compare = 0.
REQ-011 Since A's MSB is 0, any Q with MSB = 1 SHALL give compare = 0.
REQ-012 comp_button SHALL register the compare result each cycle into a level register (cmp_q).
REQ-013 Latency: a change on SW or Q that is stable before edge N SHALL appear on out after edge N (1-cycle latency).
REQ-014 out SHALL be driven only from flops; no combinational path from inputs to out.
REQ-015 SW and Q SHALL be treated as synchronous to clk; no input synchronizers are required.

Reset
REQ-016 While reset = 1 at a rising edge, out and all internal state (cmp_q, prev_cmp) SHALL become 0 on that edge.
REQ-017 The first post-reset edge SHALL load the current comparison normally.
REQ-018 Reset asserted mid-press SHALL force out = 0 on the next edge regardless of inputs.
REQ-019 Reset SHALL take priority over all other updates.

Configuration
REQ-020 Macro COMP_BUTTON_PULSE_EN SHALL select the output mode.
REQ-021 Macro defined: out SHALL pulse high for exactly one cycle when compare transitions 0->1 (registered rising-edge detect using prev_cmp).
REQ-022 Macro defined: a compare held at 1 SHALL give no further pulses until it returns to 0 and rises again.
REQ-023 Macro defined: compare = 1 on the first edge after reset SHALL count as a rising edge.
REQ-024 Macro not defined: out SHALL equal cmp_q, i.e. a level held high while compare = 1.

Verification
REQ-025 Reset held 2 cycles, then released -> out = 0 throughout reset and on the first released edge when SW = 0, Q = 0.
REQ-026 Level mode: Q = 1, SW = 2 -> out = 1 after next edge; then Q = 3 -> out = 0 after next edge.
REQ-027 Boundary check: SW = 5, Q = 5 -> out = 0; SW = 511, Q = 0 -> out = 1; SW = 511, Q = 512 -> out = 0.
REQ-028 Pulse mode: SW = 2, Q = 1 held 4 cycles -> out high exactly 1 cycle; Q = 3 for 1 cycle, then Q = 1 -> exactly one new pulse.
REQ-029 Reset mid-press: out = 1, then reset = 1 for one edge with inputs unchanged -> out = 0 on that edge.
REQ-030 Random check: 1000 random SW/Q pairs -> out matches a reference model delayed one cycle, in both macro settings.
